// File: rtl/list_buffer_pkg.sv
// Shared defaults and index/payload types for the linked-list multi-queue buffer.
// Optional runtime checks in the top are enabled by defining LIST_BUFFER_ASSERT_EN.
package list_buffer_pkg;

  localparam int QUEUES  = 2;
  localparam int ENTRIES = 4;
  localparam int DATA_W  = 4;

  // Keep index widths at least one bit so single-queue builds still elaborate.
  localparam int QW = (QUEUES  > 1) ? $clog2(QUEUES)  : 1;
  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef logic [QW-1:0]     qidx_t;
  typedef logic [EW-1:0]     eidx_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/list_buffer_free_alloc.sv
// Slot occupancy tracker: owns the used bitmap, offers the lowest free slot and
// accepts one allocate and one free per cycle. A freed slot only becomes
// allocatable after the bitmap register updates.
module list_buffer_free_alloc
  import list_buffer_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               alloc,
  input  logic               free,
  input  eidx_t              free_idx,
  output logic               ready,
  output eidx_t              alloc_idx,
  output logic [ENTRIES-1:0] used
);

  logic [ENTRIES-1:0] used_q;
  logic [ENTRIES-1:0] used_d;

  assign ready = ~&used_q;
  assign used  = used_q;

  // Priority pick of the lowest-index clear bit (scan down so low index wins).
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!used_q[i]) alloc_idx = eidx_t'(i);
    end
  end

  // Next bitmap: alloc and free never target the same slot in one cycle.
  always_comb begin
    used_d = used_q;
    if (alloc) used_d[alloc_idx] = 1'b1;
    if (free)  used_d[free_idx]  = 1'b0;
  end

  // Occupancy register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) used_q <= '0;
    else          used_q <= used_d;
  end

endmodule

// File: rtl/list_buffer_2q.sv
// Multi-queue FIFO over a shared slot pool: per-queue head/tail pointers, a
// next-pointer table linking slots, and a registered pop response.
// Define LIST_BUFFER_ASSERT_EN to enable runtime misuse checks.
// Handshake: a push fires when push_valid & push_ready; a pop fires when
// pop_valid & valid[pop_index] (no ready, callers consult valid first); a
// fired pop returns its payload one cycle later on resp_valid/resp_data.
module list_buffer_2q
  import list_buffer_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  qidx_t             push_index,
  input  data_t             push_data,
  output logic [QUEUES-1:0] valid,
  input  logic              pop_valid,
  input  qidx_t             pop_index,
  output logic              resp_valid,
  output data_t             resp_data
);

  eidx_t              head_q [QUEUES];
  eidx_t              head_d [QUEUES];
  eidx_t              tail_q [QUEUES];
  eidx_t              tail_d [QUEUES];
  eidx_t              next_q [ENTRIES];
  eidx_t              next_d [ENTRIES];
  logic [QUEUES-1:0]  valid_q;
  logic [QUEUES-1:0]  valid_d;
  data_t              data_q [ENTRIES];
  logic               resp_valid_q;
  data_t              resp_data_q;

  logic               push_fire;
  logic               pop_fire;
  eidx_t              pop_head;
  eidx_t              alloc_idx;
  logic               single_bypass;
  logic [ENTRIES-1:0] used;

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & valid_q[pop_index];
  assign pop_head  = head_q[pop_index];
  // Pop removes the only entry while a push lands on the same queue: the new
  // slot becomes both head and tail, with no link from the departing slot.
  assign single_bypass = push_fire & pop_fire & (push_index == pop_index) &
                         (tail_q[pop_index] == pop_head);

  assign valid      = valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  list_buffer_free_alloc u_free_alloc (
    .clock     (clock),
    .reset_n   (reset_n),
    .alloc     (push_fire),
    .free      (pop_fire),
    .free_idx  (pop_head),
    .ready     (push_ready),
    .alloc_idx (alloc_idx),
    .used      (used)
  );

  // Pointer-table next state: pop unlinks the head, then push appends.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    next_d  = next_q;
    valid_d = valid_q;
    if (pop_fire) begin
      head_d[pop_index] = next_q[pop_head];
      if (tail_q[pop_index] == pop_head) valid_d[pop_index] = 1'b0;
    end
    if (push_fire) begin
      tail_d[push_index]  = alloc_idx;
      valid_d[push_index] = 1'b1;
      if (single_bypass)               head_d[push_index]         = alloc_idx;
      else if (valid_q[push_index])    next_d[tail_q[push_index]] = alloc_idx;
      else                             head_d[push_index]         = alloc_idx;
    end
  end

  // Pointer tables and per-queue non-empty flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int q = 0; q < QUEUES; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
      end
      for (int e = 0; e < ENTRIES; e++) next_q[e] <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      next_q  <= next_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_fire) data_q[alloc_idx] <= push_data;
  end

  // Registered pop response; data holds between pops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= pop_fire;
      if (pop_fire) resp_data_q <= data_q[pop_head];
    end
  end

`ifdef LIST_BUFFER_ASSERT_EN
  // Misuse checks, silent while reset is held.
  always @(posedge clock) begin
    if (reset_n) begin
      if (pop_valid && !valid_q[pop_index])
        $error("list_buffer_2q: pop of empty queue %0d", pop_index);
      if (pop_valid && int'(pop_index) >= QUEUES)
        $error("list_buffer_2q: pop_index %0d out of range", pop_index);
      if (push_valid && int'(push_index) >= QUEUES)
        $error("list_buffer_2q: push_index %0d out of range", push_index);
      if (push_valid && !push_ready)
        $error("list_buffer_2q: push while full");
      if (pop_fire && !used[pop_head])
        $error("list_buffer_2q: popped slot %0d not in use", pop_head);
    end
  end
`else
  // Occupancy bitmap is only consumed by the checks above.
  logic unused_used;
  assign unused_used = ^used;
`endif

endmodule

// File: tb/tb_list_buffer_2q.sv
// Self-checking bench for list_buffer_2q: directed scenarios plus a random run
// against a queue-per-FIFO reference model.
module tb_list_buffer_2q;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [0:0] push_index = '0;
  logic [3:0] push_data = '0;
  logic [1:0] valid;
  logic       pop_valid = 1'b0;
  logic [0:0] pop_index = '0;
  logic       resp_valid;
  logic [3:0] resp_data;

  int errors = 0;
  int checks = 0;

  // Reference model: one plain queue per logical FIFO, scoreboard of pops.
  logic [3:0] m0[$];
  logic [3:0] m1[$];
  logic [3:0] exp_q[$];
  logic       exp_rv;
  logic [3:0] last_resp;

  list_buffer_2q dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_index (push_index),
    .push_data  (push_data),
    .valid      (valid),
    .pop_valid  (pop_valid),
    .pop_index  (pop_index),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  // Clock
  always #5 clock = ~clock;

  function automatic logic [1:0] exp_valid();
    return {m1.size() != 0, m0.size() != 0};
  endfunction

  function automatic logic exp_ready();
    return (m0.size() + m1.size()) < 4;
  endfunction

  // Reset block
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    push_valid = 1'b0;
    pop_valid = 1'b0;
    m0.delete();
    m1.delete();
    exp_q.delete();
    exp_rv = 1'b0;
    last_resp = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Driver: one cycle of push/pop, model updated with that cycle's rules.
  // Occupancy is judged at the start of the cycle, so a pop never makes
  // room for a push in the same cycle.
  task automatic step(input bit pv, input int pq, input int pd, input bit ov, input int oq);
    int cnt;
    bit pacc;
    bit oacc;
    logic [3:0] d;
    @(negedge clock);
    push_valid = pv;
    push_index = 1'(pq);
    push_data  = 4'(pd);
    pop_valid  = ov;
    pop_index  = 1'(oq);
    cnt  = m0.size() + m1.size();
    pacc = pv && (cnt < 4);
    oacc = ov && ((oq == 0) ? (m0.size() > 0) : (m1.size() > 0));
    if (oacc) begin
      if (oq == 0) d = m0.pop_front();
      else         d = m1.pop_front();
      exp_q.push_back(d);
      last_resp = d;
    end
    if (pacc) begin
      if (pq == 0) m0.push_back(4'(pd));
      else         m1.push_back(4'(pd));
    end
    exp_rv = oacc;
    @(posedge clock);
    #1;
    push_valid = 1'b0;
    pop_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (valid !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", valid); end
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if (resp_data !== 4'h0) begin errors++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    do_reset();
  endtask

  task automatic test_fifo_order();
    for (int i = 1; i <= 3; i++) step(1, 0, i, 0, 0);
    checks++;
    if (valid !== 2'b01) begin errors++; $display("FAIL fifo_valid_after_push got=%b exp=01", valid); end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL fifo_resp_valid got=%b exp=1", resp_valid); end
      checks++;
      if (resp_data !== 4'(i)) begin errors++; $display("FAIL fifo_resp_data got=%h exp=%h", resp_data, 4'(i)); end
      void'(exp_q.pop_front());
    end
    checks++;
    if (valid !== 2'b00) begin errors++; $display("FAIL fifo_valid_after_pop got=%b exp=00", valid); end
  endtask

  task automatic test_interleave();
    int         pq[4]  = '{0, 1, 0, 1};
    int         pd[4]  = '{10, 11, 12, 13};
    int         oq[4]  = '{1, 0, 1, 0};
    logic [3:0] exp[4] = '{4'd11, 4'd10, 4'd13, 4'd12};
    for (int i = 0; i < 4; i++) step(1, pq[i], pd[i], 0, 0);
    checks++;
    if (valid !== 2'b11) begin errors++; $display("FAIL inter_valid got=%b exp=11", valid); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, oq[i]);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp[i]) begin
        errors++;
        $display("FAIL inter_resp[%0d] got=%b/%h exp=1/%h", i, resp_valid, resp_data, exp[i]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full();
    step(1, 0, 1, 0, 0);
    step(1, 1, 2, 0, 0);
    step(1, 0, 3, 0, 0);
    step(1, 1, 4, 0, 0);
    checks++;
    if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", push_ready); end
    step(1, 0, 5, 0, 0);
    checks++;
    if (push_ready !== 1'b0 || valid !== 2'b11) begin
      errors++;
      $display("FAIL full_ignored got=%b/%b exp=0/11", push_ready, valid);
    end
    // Pop frees a slot but the same-cycle push is still refused.
    step(1, 1, 6, 1, 0);
    checks++;
    if (resp_data !== 4'd1 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got=%h/%b exp=1/1", resp_data, push_ready);
    end
    void'(exp_q.pop_front());
    step(1, 1, 6, 0, 0);
    checks++;
    if (push_ready !== 1'b0) begin errors++; $display("FAIL full_refill got=%b exp=0", push_ready); end
    // Drain: q0 has 3, q1 has 2,4,6.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    begin
      logic [3:0] exp[4] = '{4'd3, 4'd2, 4'd4, 4'd6};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0] !== exp[i]) begin
          errors++;
          $display("FAIL full_model_order[%0d] model=%0d exp=%h", i, exp_q.size(), exp[i]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (resp_data !== 4'd6 || valid !== 2'b00) begin
      errors++;
      $display("FAIL full_drain got=%h/%b exp=6/00", resp_data, valid);
    end
  endtask

  task automatic test_single_entry_pushpop();
    step(1, 1, 7, 0, 0);
    step(1, 1, 9, 1, 1);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 4'd7) begin
      errors++;
      $display("FAIL single_resp got=%b/%h exp=1/7", resp_valid, resp_data);
    end
    checks++;
    if (valid !== 2'b10) begin errors++; $display("FAIL single_valid got=%b exp=10", valid); end
    step(0, 0, 0, 1, 1);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 4'd9) begin
      errors++;
      $display("FAIL single_second got=%b/%h exp=1/9", resp_valid, resp_data);
    end
    checks++;
    if (valid !== 2'b00) begin errors++; $display("FAIL single_empty got=%b exp=00", valid); end
    exp_q.delete();
  endtask

  task automatic test_empty_pop();
    step(0, 0, 0, 1, 0);
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL empty_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if (resp_data !== last_resp) begin errors++; $display("FAIL empty_resp_hold got=%h exp=%h", resp_data, last_resp); end
    checks++;
    if (valid !== 2'b00 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_state got=%b/%b exp=00/1", valid, push_ready);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 0, 0);
    step(1, 0, 2, 0, 0);
    step(1, 1, 3, 0, 0);
    @(negedge clock);
    pop_valid = 1'b1;
    pop_index = 1'b0;
    @(posedge clock);
    #1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (valid !== 2'b00) begin errors++; $display("FAIL areset_valid got=%b exp=00", valid); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL areset_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL areset_push_ready got=%b exp=1", push_ready); end
    pop_valid = 1'b0;
    m0.delete();
    m1.delete();
    exp_q.delete();
    last_resp = '0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 0, 5, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 4'd5) begin
      errors++;
      $display("FAIL areset_after got=%b/%h exp=1/5", resp_valid, resp_data);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [3:0] exp_d;
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 1));
      exp_d = last_resp;
      if (exp_rv) exp_d = exp_q.pop_front();
      checks++;
      if (resp_valid !== exp_rv) begin errors++; $display("FAIL rand_resp_valid[%0d] got=%b exp=%b", n, resp_valid, exp_rv); end
      checks++;
      if (resp_data !== exp_d) begin errors++; $display("FAIL rand_resp_data[%0d] got=%h exp=%h", n, resp_data, exp_d); end
      checks++;
      if (valid !== exp_valid()) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", n, valid, exp_valid()); end
      checks++;
      if (push_ready !== exp_ready()) begin errors++; $display("FAIL rand_push_ready[%0d] got=%b exp=%b", n, push_ready, exp_ready()); end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_fifo_order();
    test_interleave();
    test_full();
    test_single_entry_pushpop();
    test_empty_pop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
